// File: rtl/array_index_bank.sv
// array_index_bank: indexed lane register bank with written flags and a one-deep read response register
module array_index_bank #(
   parameter int WIDTH     = 8,
   parameter int NUM_LANES = 2,
   parameter int IDX_W     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IDX_W-1:0] req_idx,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);
   logic [WIDTH-1:0]     lane [NUM_LANES];
   logic [NUM_LANES-1:0] written;
   logic [WIDTH-1:0]     rd_data;
   logic                 rd_ok;
   logic                 accept;

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [WIDTH-1:0] q;
      logic             w;
      // lane storage: clear wins over write; stored value is data plus lane number
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q <= '0;
            w <= 1'b0;
         end else if (clr) begin
            q <= '0;
            w <= 1'b0;
         end else if (wr_en && wr_idx == IDX_W'(i)) begin
            q <= wr_data + WIDTH'(i);
            w <= 1'b1;
         end
      end
      assign lane[i]    = q;
      assign written[i] = w;
   end

   // read mux: out-of-range indices match no lane and fall through to the error default
   always_comb begin
      rd_data = '0;
      rd_ok   = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (req_idx == IDX_W'(k)) begin
            rd_data = lane[k];
            rd_ok   = written[k];
         end
      end
   end

   // response register: load on accept, zero out when the consumer drains it, hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_data  <= rd_ok ? rd_data : '0;
         rsp_err   <= !rd_ok;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_array_index_bank.sv
// tb_array_index_bank: directed vector table plus hand sequences for the lane bank
module tb_array_index_bank;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_wr_en = 1'b0, m_wr_idx = 1'b0, m_clr = 1'b0, m_req_valid = 1'b0, m_req_idx = 1'b0, m_rsp_ready = 1'b1;
   logic [7:0] m_wr_data = 8'h00;
   logic       m_req_ready, m_rsp_valid, m_rsp_err;
   logic [7:0] m_rsp_data;
   logic       t_wr_en = 1'b0, t_clr = 1'b0, t_req_valid = 1'b0, t_rsp_ready = 1'b1;
   logic [1:0] t_wr_idx = 2'd0, t_req_idx = 2'd0;
   logic [7:0] t_wr_data = 8'h00;
   logic       t_req_ready, t_rsp_valid, t_rsp_err;
   logic [7:0] t_rsp_data;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      logic       we;
      logic       wi;
      logic [7:0] wd;
      logic       c;
      logic       qv;
      logic       qi;
      logic       rr;
      logic       ev;
      logic [7:0] ed;
      logic       ee;
      logic       erdy;
   } vec_t;
   vec_t vt [17];

   always #5 clk = ~clk;

   array_index_bank u_dut (
      .clk(clk), .rst(rst), .wr_en(m_wr_en), .wr_idx(m_wr_idx), .wr_data(m_wr_data), .clr(m_clr),
      .req_valid(m_req_valid), .req_ready(m_req_ready), .req_idx(m_req_idx),
      .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_data(m_rsp_data), .rsp_err(m_rsp_err)
   );

   array_index_bank #(.WIDTH(8), .NUM_LANES(3), .IDX_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .wr_en(t_wr_en), .wr_idx(t_wr_idx), .wr_data(t_wr_data), .clr(t_clr),
      .req_valid(t_req_valid), .req_ready(t_req_ready), .req_idx(t_req_idx),
      .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic exp_m(input string nm, input logic v, input logic [7:0] d, input logic e, input logic r);
      chk({nm, ".rsp_valid"}, 32'(m_rsp_valid), 32'(v));
      chk({nm, ".rsp_data"}, 32'(m_rsp_data), 32'(d));
      chk({nm, ".rsp_err"}, 32'(m_rsp_err), 32'(e));
      chk({nm, ".req_ready"}, 32'(m_req_ready), 32'(r));
   endtask

   task automatic exp_t(input string nm, input logic v, input logic [7:0] d, input logic e);
      chk({nm, ".rsp_valid"}, 32'(t_rsp_valid), 32'(v));
      chk({nm, ".rsp_data"}, 32'(t_rsp_data), 32'(d));
      chk({nm, ".rsp_err"}, 32'(t_rsp_err), 32'(e));
   endtask

   task automatic drive_m(input logic we, input logic wi, input logic [7:0] wd, input logic c,
                          input logic qv, input logic qi, input logic rr);
      @(negedge clk);
      m_wr_en = we; m_wr_idx = wi; m_wr_data = wd; m_clr = c;
      m_req_valid = qv; m_req_idx = qi; m_rsp_ready = rr;
   endtask

   task automatic drive_t(input logic we, input logic [1:0] wi, input logic [7:0] wd,
                          input logic qv, input logic [1:0] qi);
      @(negedge clk);
      t_wr_en = we; t_wr_idx = wi; t_wr_data = wd; t_req_valid = qv; t_req_idx = qi;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          we    wi    wd     c     qv    qi    rr      ev    ed     ee    erdy
      vt[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1,   1'b0, 8'h00, 1'b0, 1'b1};
      vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1,   1'b1, 8'h00, 1'b0, 1'b1};
      vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h00, 1'b1, 1'b1};
      vt[3]  = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1,   1'b0, 8'h00, 1'b0, 1'b1};
      vt[4]  = '{1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h05, 1'b0, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h10, 1'b0, 1'b1};
      vt[6]  = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b1,   1'b1, 8'h00, 1'b0, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1,   1'b1, 8'h21, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1,   1'b1, 8'h21, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1,   1'b1, 8'h00, 1'b1, 1'b1};
      vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h00, 1'b1, 1'b1};
      vt[11] = '{1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1,   1'b0, 8'h00, 1'b0, 1'b1};
      vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h7F, 1'b0, 1'b1};
      vt[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,   1'b1, 8'h7F, 1'b0, 1'b0};
      vt[14] = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h7F, 1'b0, 1'b1};
      vt[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1,   1'b1, 8'h7F, 1'b0, 1'b1};
      vt[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1,   1'b0, 8'h00, 1'b0, 1'b1};

      #2;
      exp_m("reset", 1'b0, 8'h00, 1'b0, 1'b1);
      exp_t("reset3", 1'b0, 8'h00, 1'b0);
      tick();
      exp_m("reset_edge", 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      drive_t(1'b1, 2'd3, 8'h11, 1'b0, 2'd0);
      tick();
      exp_t("t_wr3", 1'b0, 8'h00, 1'b0);
      drive_t(1'b1, 2'd2, 8'h11, 1'b1, 2'd3);
      tick();
      exp_t("t_rd3", 1'b1, 8'h00, 1'b1);
      drive_t(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
      tick();
      exp_t("t_rd2", 1'b1, 8'h13, 1'b0);
      drive_t(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
      tick();
      exp_t("t_rd0", 1'b1, 8'h00, 1'b1);
      drive_t(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
      tick();
      exp_t("t_rd1", 1'b1, 8'h00, 1'b1);
      drive_t(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
      tick();
      exp_t("t_idle", 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 17; i++) begin
         drive_m(vt[i].we, vt[i].wi, vt[i].wd, vt[i].c, vt[i].qv, vt[i].qi, vt[i].rr);
         tick();
         exp_m($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].ee, vt[i].erdy);
      end

      drive_m(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      exp_m("bp_wr", 1'b0, 8'h00, 1'b0, 1'b1);
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      exp_m("bp_load", 1'b1, 8'h41, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_m(1'b1, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
         exp_m($sformatf("bp_hold%0d", i), 1'b1, 8'h41, 1'b0, 1'b0);
      end
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      exp_m("bp_rel0", 1'b1, 8'h50, 1'b0, 1'b1);
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      exp_m("bp_rel1", 1'b1, 8'h41, 1'b0, 1'b1);
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      exp_m("bp_drain", 1'b0, 8'h00, 1'b0, 1'b1);

      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      exp_m("rst_pre", 1'b1, 8'h50, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      exp_m("rst_async", 1'b0, 8'h00, 1'b0, 1'b1);
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      @(negedge clk);
      rst = 1'b0;
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      exp_m("rst_rd0", 1'b1, 8'h00, 1'b1, 1'b1);
      drive_m(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      exp_m("rst_rd1", 1'b1, 8'h00, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/array_index_bank.md
ARRAY_INDEX_BANK -- requirements
Module: array_index_bank

Interface
REQ-001 Parameter WIDTH, default 8, lane data width in bits (>=1).
REQ-002 Parameter NUM_LANES, default 2, number of lane registers (>=1).
REQ-003 Parameter IDX_W, default 1, index width; SHALL satisfy 2**IDX_W >= NUM_LANES.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe, one write per cycle when high.
REQ-007 wr_idx  input  IDX_W  target lane of write.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 clr  input  1  clear all lanes (synchronous command).
REQ-010 req_valid  input  1  read request valid.
REQ-011 req_ready  output  1  read request can be accepted.
REQ-012 req_idx  input  IDX_W  lane to read.
REQ-013 rsp_valid  output  1  read response valid.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_data  output  WIDTH  read result.
REQ-016 rsp_err  output  1  request index out of range or lane never written.

Function
REQ-017 Block SHALL hold NUM_LANES lane registers lane[i] (WIDTH bits) plus one written flag per lane, built by a generate loop over i.
REQ-018 Write: wr_en high and wr_idx < NUM_LANES -> lane[wr_idx] <= wr_data + wr_idx (truncated modulo 2**WIDTH), written[wr_idx] <= 1, next edge.
REQ-019 Write with wr_idx >= NUM_LANES SHALL be dropped with no state change.
REQ-020 clr high SHALL zero every lane and every written flag next edge; clr SHALL take priority over a same-cycle write.
REQ-021 req_ready SHALL equal (!rsp_valid || rsp_ready); request accepted when req_valid && req_ready.
REQ-022 Accepted request SHALL load the response register next edge: rsp_valid <= 1, latency exactly one cycle.
REQ-023 In-range, written lane -> rsp_data = lane[req_idx], rsp_err = 0.
REQ-024 req_idx >= NUM_LANES or written[req_idx] = 0 -> rsp_data = 0, rsp_err = 1.
REQ-025 Read and write/clr to the same lane in the same cycle SHALL return the pre-update value and flag (read-before-write).
REQ-026 rsp_valid high and rsp_ready low -> rsp_data, rsp_err, rsp_valid SHALL hold stable; no new request accepted.
REQ-027 rsp_valid && rsp_ready with no accepted request -> rsp_valid <= 0 next edge; with accepted request -> back-to-back response, one per cycle.
REQ-028 rsp_data and rsp_err SHALL be 0 whenever rsp_valid is 0 after a handshake completes or after reset.
REQ-029 Writes and clr SHALL proceed independently of response backpressure.

Reset
REQ-030 rst high SHALL immediately (asynchronously) force all lanes to 0, all written flags to 0, rsp_valid 0, rsp_data 0, rsp_err 0.
REQ-031 req_ready SHALL read 1 during and after reset (rsp_valid is 0).
REQ-032 Reset asserted mid-transaction SHALL discard any pending response; first edge after rst release behaves as from power-up.

Verification
REQ-033 Defaults: write wr_idx=1, wr_data=8'hFF, then read idx 1 -> one cycle later rsp_valid=1, rsp_data=8'h00 (wrap), rsp_err=0.
REQ-034 Read idx 0 never written -> rsp_data=0, rsp_err=1; NUM_LANES=3, IDX_W=2, read idx 3 -> rsp_data=0, rsp_err=1; write idx 3 ignored.
REQ-035 Same-cycle write lane 0 (data 8'h10) and read lane 0 holding 8'h05 -> rsp_data=8'h05; next read -> 8'h10.
REQ-036 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable; release -> one response per cycle thereafter.
REQ-037 clr with same-cycle write to lane 1 -> all lanes 0, written flags 0; subsequent read lane 1 -> rsp_err=1.
REQ-038 Assert rst while rsp_valid=1 -> rsp_valid, rsp_data, rsp_err drop to 0 before next clock edge; stored lanes read back with rsp_err=1.
